ps2_frame_rx: RTL

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

---
 rtl/ps2_frame_rx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: sync, SCL deglitch, 11-bit frame FSM.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   SCL, SDA        - raw PS/2 clock/data lines (asynchronous)
//   data_valid      - 1-cycle pulse: good byte loaded into data_out
//   data_out[7:0]   - last good scan code, held between frames
//   parity_err      - 1-cycle pulse: odd-parity check failed
//   frame_err       - 1-cycle pulse: bad stop bit or timeout abort
module ps2_frame_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL,
  input  logic       SDA,
  output logic       data_valid,
  output logic [7:0] data_out,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic          scl_s1_q, scl_s2_q;
  logic          sda_s1_q, sda_s2_q;
  logic          scl_f_q, scl_f_d;
  logic          scl_fd_q;
  logic [FW-1:0] flt_q, flt_d;
  state_t        state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_q, bit_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    dout_q, dout_d;
  logic          dv_q, dv_d;
  logic          pe_q, pe_d;
  logic          fe_q, fe_d;
  logic          afe;
  logic          tmo_hit;
  logic          par_good;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      scl_f_q  <= 1'b1;
      scl_fd_q <= 1'b1;
      flt_q    <= '0;
      state_q  <= IDLE;
      sh_q     <= '0;
      bit_q    <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      scl_s1_q <= SCL;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= SDA;
      sda_s2_q <= sda_s1_q;
      scl_f_q  <= scl_f_d;
      scl_fd_q <= scl_f_q;
      flt_q    <= flt_d;
      state_q  <= state_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
    end
  end

  // Count consecutive samples disagreeing with the filtered level;
  // any agreeing sample restarts the run.
  always_comb begin
    flt_d   = '0;
    scl_f_d = scl_f_q;
    if (scl_s2_q != scl_f_q) begin
      if (flt_q == FW'(FILTER_LEN - 1)) begin
        scl_f_d = scl_s2_q;
      end else begin
        flt_d = flt_q + 1'b1;
      end
    end
  end

  assign afe      = scl_fd_q & ~scl_f_q;
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign par_good = ^{sh_q, par_q};

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    par_d   = par_q;
    tmo_d   = tmo_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (afe && !sda_s2_q) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (afe) begin
          sh_d  = {sda_s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (afe) begin
          par_d   = sda_s2_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (afe) begin
          state_d = IDLE;
          if (!sda_s2_q) begin
            fe_d = 1'b1;
          end else if (par_good) begin
            dout_d = sh_q;
            dv_d   = 1'b1;
          end else begin
            pe_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An edge beats a coincident timeout: the frame is still alive.
    if (state_q != IDLE) begin
      if (afe) begin
        tmo_d = '0;
      end else if (tmo_hit) begin
        state_d = IDLE;
        fe_d    = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign data_valid = dv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign data_out   = dout_q;

endmodule
